char_stream_normalizer: RTL and testbench

- Upstream feeder for the begin/end block-nesting checker. Accepts raw ASCII bytes from a byte source over a valid/ready handshake.
- Normalises each byte: case fold, whitespace mapping, collapse of repeated whitespace.
- Buffers normalised bytes in a small FIFO and presents them one per cycle with out_valid.
- The checker advances only on cycles where out_valid && out_ready, so idle gaps never split a word.

---
 rtl/char_pkg.sv | 31 +++
 rtl/char_stream_normalizer_if.sv | 9 +
 rtl/char_fifo.sv | 53 +++++
 rtl/char_stream_normalizer.sv | 71 +++++++
 tb/tb_char_stream_normalizer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/char_pkg.sv
// Shared ASCII constants and the byte normalisation function for the
// char_stream_normalizer and the begin/end nesting checker.
package char_pkg;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_TAB  = 8'h09;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_DEL  = 8'h7F;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_Z = 8'h5A;
  localparam logic [7:0] CASE_OFS   = 8'h20;

  function automatic logic is_ws_ctrl(input logic [7:0] b);
    return (b == ASCII_TAB) || (b == ASCII_LF) || (b == ASCII_CR);
  endfunction

  // Control characters other than tab/LF/CR, plus DEL and the upper half.
  function automatic logic is_bad_byte(input logic [7:0] b);
    return ((b < ASCII_SP) && !is_ws_ctrl(b)) || (b >= ASCII_DEL);
  endfunction

  function automatic logic [7:0] normalise_byte(input logic [7:0] b);
    if ((b >= ASCII_UC_A) && (b <= ASCII_UC_Z)) return b + CASE_OFS;
    else if (is_ws_ctrl(b))                     return ASCII_SP;
    else if (is_bad_byte(b))                    return ASCII_QM;
    else                                        return b;
  endfunction

endpackage

// File: rtl/char_stream_normalizer_if.sv
// Byte stream with valid/ready handshake; master drives valid/data.
interface char_stream_normalizer_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/char_fifo.sv
// First-word-fall-through byte FIFO with occupancy count; DEPTH must be a
// power of two so the pointers wrap by natural overflow.
module char_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; rdata is gated by empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/char_stream_normalizer.sv
// Case-folds, maps whitespace and collapses repeated spaces on a byte stream
// feeding the nesting checker. Define CHAR_NORM_STATS_EN to add drop_cnt.
module char_stream_normalizer
  import char_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  char_stream_normalizer_if.slave  in_if,
  char_stream_normalizer_if.master out_if,
`ifdef CHAR_NORM_STATS_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic                     bad_char
);

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_rdata;
  logic [7:0]       norm;
  logic             accept;
  logic             drop;
  logic             last_sp;

  assign in_if.ready  = !fifo_full;
  assign accept       = in_if.valid && in_if.ready;
  assign norm         = normalise_byte(in_if.data);
  assign drop         = (norm == ASCII_SP) && last_sp;
  assign out_if.valid = !fifo_empty;
  assign out_if.data  = fifo_rdata;

  // last_sp starts high so whitespace at the start of a stream is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_sp  <= 1'b1;
      bad_char <= 1'b0;
    end else if (accept) begin
      last_sp <= (norm == ASCII_SP);
      if (is_bad_byte(in_if.data)) bad_char <= 1'b1;
    end
  end

`ifdef CHAR_NORM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               drop_cnt <= '0;
    else if (accept && drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  char_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept && !drop),
    .wdata   (norm),
    .pop     (out_if.valid && out_if.ready),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  a_empty_count: assert property (@(posedge clk) disable iff (!reset_n)
    fifo_empty == (fifo_count == '0));

endmodule

// File: tb/tb_char_stream_normalizer.sv
// Directed bench for char_stream_normalizer; expected bytes are hand-derived.
module tb_char_stream_normalizer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic bad_char;
`ifdef CHAR_NORM_STATS_EN
  logic [15:0] drop_cnt;
`endif

  char_stream_normalizer_if in_if ();
  char_stream_normalizer_if out_if ();

  char_stream_normalizer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_if    (in_if),
    .out_if   (out_if),
`ifdef CHAR_NORM_STATS_EN
    .drop_cnt (drop_cnt),
`endif
    .bad_char (bad_char)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_if.valid = 1'b1;
    in_if.data  = b;
    tick();
    in_if.valid = 1'b0;
  endtask

  // Pops exp_q in order, one byte per cycle, then expects an empty FIFO.
  task automatic drain();
    out_if.ready = 1'b1;
    foreach (exp_q[k]) begin
      check_val($sformatf("drain_vld%0d", k), {31'd0, out_if.valid}, 32'd1);
      check_val($sformatf("drain_dat%0d", k), {24'd0, out_if.data}, {24'd0, exp_q[k]});
      tick();
    end
    check_val("drain_empty", {31'd0, out_if.valid}, 32'd0);
    out_if.ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    check_val("rst_vld", {31'd0, out_if.valid}, 32'd0);
    check_val("rst_cnt", {28'd0, dut.u_fifo.count}, 32'd0);
    tick();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] gen_byte(input int i);
    return 8'h61 + 8'((i * 7) % 26);
  endfunction

  logic [7:0] word [5];

  initial begin
    reset_n      = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = 8'h00;
    out_if.ready = 1'b0;
    #12;
    check_val("reset_vld", {31'd0, out_if.valid}, 32'd0);
    check_val("reset_dat", {24'd0, out_if.data}, 32'h00);
    check_val("reset_rdy", {31'd0, in_if.ready}, 32'd1);
    check_val("reset_bad", {31'd0, bad_char}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Mid-stream reset with three bytes buffered.
    send(8'h78); send(8'h79); send(8'h7A);
    check_val("buf3_cnt", {28'd0, dut.u_fifo.count}, 32'd3);
    #2;
    pulse_reset();
    check_val("post_rst_vld", {31'd0, out_if.valid}, 32'd0);
    send(8'h62);
    check_val("b_vld", {31'd0, out_if.valid}, 32'd1);
    check_val("b_dat", {24'd0, out_if.data}, 32'h62);
    exp_q = '{8'h62};
    drain();

    // "BeGiN" streamed with the consumer always ready.
    word = '{8'h42, 8'h65, 8'h47, 8'h69, 8'h4E};
    exp_q = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E};
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_if.data = word[i];
      tick();
      check_val($sformatf("begin_vld%0d", i), {31'd0, out_if.valid}, 32'd1);
      check_val($sformatf("begin_dat%0d", i), {24'd0, out_if.data}, {24'd0, exp_q[i]});
    end
    in_if.valid = 1'b0;
    tick();
    check_val("begin_done", {31'd0, out_if.valid}, 32'd0);
    out_if.ready = 1'b0;

    // Whitespace mapping and collapse from a fresh last_sp.
    pulse_reset();
    send(8'h20); send(8'h09); send(8'h0A); send(8'h65);
    send(8'h20); send(8'h20); send(8'h0D); send(8'h6E);
    check_val("ws_cnt", {28'd0, dut.u_fifo.count}, 32'd3);
`ifdef CHAR_NORM_STATS_EN
    check_val("ws_drop_cnt", {16'd0, drop_cnt}, 32'd5);
`endif
    exp_q = '{8'h65, 8'h20, 8'h6E};
    drain();

    // Fill to DEPTH with the consumer stalled, then release.
    for (int i = 0; i < DEPTH; i++) begin
      check_val($sformatf("fill_rdy%0d", i), {31'd0, in_if.ready}, 32'd1);
      send(8'h61 + 8'(i));
    end
    check_val("full_rdy", {31'd0, in_if.ready}, 32'd0);
    check_val("full_head", {24'd0, out_if.data}, 32'h61);
    in_if.valid  = 1'b1;
    in_if.data   = 8'h69;
    out_if.ready = 1'b1;
    tick();
    check_val("nobypass_cnt", {28'd0, dut.u_fifo.count}, 32'd7);
    check_val("rdy_rise", {31'd0, in_if.ready}, 32'd1);
    check_val("head_b", {24'd0, out_if.data}, 32'h62);
    tick();
    in_if.valid = 1'b0;
    exp_q = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
    drain();

    // Non-printable bytes become '?' and set the sticky flag.
    check_val("bad_pre", {31'd0, bad_char}, 32'd0);
    send(8'h01); send(8'h80);
    exp_q = '{8'h3F, 8'h3F};
    drain();
    tick(); tick();
    check_val("bad_held", {31'd0, bad_char}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("bad_clr", {31'd0, bad_char}, 32'd0);
    tick();
    @(negedge clk);
    reset_n = 1'b1;

    // Sustained push+pop at count=1 across repeated pointer wraps.
    send(gen_byte(0));
    check_val("pp_head0", {24'd0, out_if.data}, {24'd0, gen_byte(0)});
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      in_if.data = gen_byte(i);
      tick();
      check_val($sformatf("pp_dat%0d", i), {24'd0, out_if.data}, {24'd0, gen_byte(i)});
      check_val($sformatf("pp_cnt%0d", i), {28'd0, dut.u_fifo.count}, 32'd1);
    end
    in_if.valid = 1'b0;
    tick();
    check_val("pp_empty", {31'd0, out_if.valid}, 32'd0);
    out_if.ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
